mmio_command_host: RTL and testbench

MMIO initiator that drives an `mmio_if.host` port from a simple valid/ready command stream and returns one response per command. It is the requesting end of the MMIO protocol that the system mapper and the control, block and memory targets answer. Typical placement: between a debug/test command source (UART or JTAG bridge, testbench driver) and the system mapper's device-side port. It adds bounded-wait timeout detection so that a silent target cannot hang the command source.

---
 rtl/mmio_command_host.sv | 103 ++++++++++
 tb/tb_mmio_command_host.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/mmio_command_host.sv
// mmio_command_host: turns a valid/ready command stream into MMIO host requests and returns one response per command.
// A silent target is abandoned after TIMEOUT_CYCLES request cycles and reported as an error response.
module mmio_command_host #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int COUNT_WIDTH    = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_write,
    input  logic [31:0]            cmd_index,
    input  logic [31:0]            cmd_data,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic                   rsp_write,
    output logic                   rsp_error,
    output logic [31:0]            rsp_data,
    output logic [COUNT_WIDTH-1:0] timeout_count,
    output logic                   read_req,
    output logic [31:0]            read_index,
    input  logic                   read_ack,
    input  logic [31:0]            read_data,
    output logic                   write_req,
    output logic [31:0]            write_index,
    output logic [31:0]            write_data,
    input  logic                   write_ack
);
    localparam int WW = $clog2(TIMEOUT_CYCLES);
    typedef enum logic [1:0] {IDLE, READ, WRITE, RESPOND} state_t;
    state_t                 r_state;
    state_t                 w_next;
    logic                   r_write;
    logic                   r_error;
    logic [31:0]            r_index;
    logic [31:0]            r_data;
    logic [31:0]            r_rdata;
    logic [WW-1:0]          r_wait;
    logic [COUNT_WIDTH-1:0] r_tcount;
    logic                   w_busy;
    logic                   w_ack;
    logic                   w_expire;
    assign w_busy   = (r_state == READ) || (r_state == WRITE);
    assign w_ack    = ((r_state == READ) && read_ack) || ((r_state == WRITE) && write_ack);
    // an ack on the threshold cycle takes priority over the timeout
    assign w_expire = w_busy && !w_ack && (r_wait == WW'(TIMEOUT_CYCLES - 1));
    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:        if (cmd_valid) w_next = cmd_write ? WRITE : READ;
            READ, WRITE: if (w_ack || w_expire) w_next = RESPOND;
            RESPOND:     if (rsp_ready) w_next = IDLE;
            default:     w_next = IDLE;
        endcase
    end
    // requests decode from state only, so they drop the cycle after the ack
    always_comb begin
        cmd_ready   = r_state == IDLE;
        rsp_valid   = r_state == RESPOND;
        read_req    = r_state == READ;
        write_req   = r_state == WRITE;
        read_index  = read_req  ? r_index : '0;
        write_index = write_req ? r_index : '0;
        write_data  = write_req ? r_data  : '0;
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_write  <= 1'b0;
            r_error  <= 1'b0;
            r_index  <= '0;
            r_data   <= '0;
            r_rdata  <= '0;
            r_wait   <= '0;
            r_tcount <= '0;
        end else if (r_state == IDLE) begin
            if (cmd_valid) begin
                r_write <= cmd_write;
                r_index <= cmd_index;
                r_data  <= cmd_data;
                r_wait  <= '0;
            end
        end else if (w_busy) begin
            if (w_ack) begin
                r_rdata <= (r_state == READ) ? read_data : '0;
                r_error <= 1'b0;
            end else if (w_expire) begin
                r_rdata <= '0;
                r_error <= 1'b1;
                if (!(&r_tcount)) r_tcount <= r_tcount + COUNT_WIDTH'(1);
            end else begin
                r_wait <= r_wait + WW'(1);
            end
        end
    end
    assign rsp_write     = r_write;
    assign rsp_error     = r_error;
    assign rsp_data      = r_rdata;
    assign timeout_count = r_tcount;
endmodule

// File: tb/tb_mmio_command_host.sv
// tb_mmio_command_host: directed checks of the MMIO command host with a scripted target.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_mmio_command_host;
    logic        clock = 1'b0;
    logic        reset;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_index, cmd_data;
    logic        rsp_valid, rsp_ready, rsp_write, rsp_error;
    logic [31:0] rsp_data;
    logic [1:0]  timeout_count;
    logic        read_req, read_ack, write_req, write_ack;
    logic [31:0] read_index, read_data, write_index, write_data;
    int n_chk = 0;
    int n_fail = 0;
    int reqs, lat;
    logic stable;

    mmio_command_host #(.TIMEOUT_CYCLES(8), .COUNT_WIDTH(2)) dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_index(cmd_index), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_error(rsp_error), .rsp_data(rsp_data), .timeout_count(timeout_count),
        .read_req(read_req), .read_index(read_index), .read_ack(read_ack), .read_data(read_data),
        .write_req(write_req), .write_index(write_index), .write_data(write_data), .write_ack(write_ack)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one command from a falling edge; the target acks dly cycles after the request rises (dly < 0: never).
    // Returns at the falling edge where rsp_valid is first seen; lat counts cycles from acceptance.
    task automatic do_cmd(input logic wr, input logic [31:0] idx, input logic [31:0] dat, input int dly,
                          input logic [31:0] ack_dat, output int n_req, output int n_lat, output logic ok);
        cmd_valid = 1'b1; cmd_write = wr; cmd_index = idx; cmd_data = dat;
        @(negedge clock);
        cmd_valid = 1'b0;
        n_lat = 1; n_req = 0; ok = 1'b1;
        while (rsp_valid !== 1'b1 && n_lat < 60) begin
            if ((wr ? write_req : read_req) === 1'b1) begin
                n_req++;
                if (wr) ok &= (write_index === idx) && (write_data === dat) && (read_req === 1'b0);
                else    ok &= (read_index === idx) && (write_req === 1'b0);
            end
            read_ack  = !wr && (read_req === 1'b1) && (n_req - 1 == dly);
            write_ack = wr && (write_req === 1'b1) && (n_req - 1 == dly);
            read_data = ack_dat;
            @(negedge clock);
            n_lat++;
        end
        read_ack = 1'b0; write_ack = 1'b0;
    endtask

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_index = '0; cmd_data = '0;
        rsp_ready = 1'b1; read_ack = 1'b0; read_data = '0; write_ack = 1'b0;
        @(negedge clock);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_fields", {rsp_write, rsp_error, rsp_data}, 0);
        chk("rst_reqs", {read_req, write_req, read_index, write_index}, 0);
        chk("rst_wdata", write_data, 0);
        chk("rst_tcount", timeout_count, 0);
        reset = 1'b0;
        @(negedge clock);
        // read, same-cycle ack
        do_cmd(1'b0, 32'h4000_0002, 32'h0, 0, 32'hDEAD_BEEF, reqs, lat, stable);
        chk("rd_req_cycles", reqs, 1);
        chk("rd_latency", lat, 2);
        chk("rd_stable", stable, 1);
        chk("rd_rsp", {rsp_valid, rsp_write, rsp_error, rsp_data}, {3'b100, 32'hDEAD_BEEF});
        @(negedge clock);
        chk("rd_done", {cmd_ready, rsp_valid}, 2'b10);
        // write, ack 3 cycles late
        do_cmd(1'b1, 32'h5, 32'h1234_5678, 3, 32'hFFFF_FFFF, reqs, lat, stable);
        chk("wr_req_cycles", reqs, 4);
        chk("wr_latency", lat, 5);
        chk("wr_stable", stable, 1);
        chk("wr_rsp", {rsp_valid, rsp_write, rsp_error, rsp_data}, {3'b110, 32'h0});
        @(negedge clock);
        chk("wr_done", {cmd_ready, rsp_valid, write_req}, 3'b100);
        // read timeout
        do_cmd(1'b0, 32'h99, 32'h0, -1, 32'h1111_1111, reqs, lat, stable);
        chk("to_req_cycles", reqs, 8);
        chk("to_latency", lat, 9);
        chk("to_rsp", {rsp_valid, rsp_write, rsp_error, rsp_data}, {3'b101, 32'h0});
        chk("to_tcount", timeout_count, 1);
        @(negedge clock);
        read_ack = 1'b1; write_ack = 1'b1; read_data = 32'h2222_2222;
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            chk("late_ack_idle", {cmd_ready, rsp_valid, read_req, write_req}, 4'b1000);
            chk("late_ack_tcount", timeout_count, 1);
        end
        read_ack = 1'b0; write_ack = 1'b0;
        // ack exactly on the threshold cycle
        do_cmd(1'b0, 32'h7, 32'h0, 7, 32'h0BAD_CAFE, reqs, lat, stable);
        chk("thr_req_cycles", reqs, 8);
        chk("thr_rsp", {rsp_valid, rsp_error, rsp_data}, {2'b10, 32'h0BAD_CAFE});
        chk("thr_tcount", timeout_count, 1);
        @(negedge clock);
        // response back-pressure with a pending command and stray acks
        rsp_ready = 1'b0;
        do_cmd(1'b0, 32'h77, 32'h0, 0, 32'hCAFE_F00D, reqs, lat, stable);
        chk("hold_latency", lat, 2);
        for (int i = 0; i < 5; i++) begin
            chk("hold_rsp", {rsp_valid, rsp_error, rsp_write, rsp_data}, {3'b100, 32'hCAFE_F00D});
            chk("hold_cmd_ready", cmd_ready, 0);
            cmd_valid = 1'b1; cmd_write = 1'b1; cmd_index = 32'h9; cmd_data = 32'hA5A5_A5A5;
            read_ack = 1'b1; write_ack = 1'b1; read_data = i;
            @(negedge clock);
        end
        read_ack = 1'b0; write_ack = 1'b0;
        chk("hold_rsp_end", {rsp_valid, cmd_ready, rsp_data}, {2'b10, 32'hCAFE_F00D});
        rsp_ready = 1'b1;
        @(negedge clock);
        chk("hold_release", {cmd_ready, rsp_valid, write_req}, 3'b100);
        @(negedge clock);
        cmd_valid = 1'b0;
        chk("hold_next_accept", {cmd_ready, write_req, write_index, write_data}, {2'b01, 32'h9, 32'hA5A5_A5A5});
        write_ack = 1'b1;
        @(negedge clock);
        write_ack = 1'b0;
        chk("hold_next_rsp", {rsp_valid, rsp_write, rsp_error, rsp_data}, {3'b110, 32'h0});
        @(negedge clock);
        // timeout counter saturation at 3
        do_cmd(1'b1, 32'h100, 32'h55, -1, 32'h0, reqs, lat, stable);
        chk("sat_wr_to", {rsp_valid, rsp_write, rsp_error, rsp_data}, {3'b111, 32'h0});
        chk("sat_tcount2", timeout_count, 2);
        @(negedge clock);
        do_cmd(1'b0, 32'h101, 32'h0, -1, 32'h0, reqs, lat, stable);
        chk("sat_tcount3", timeout_count, 3);
        @(negedge clock);
        do_cmd(1'b0, 32'h102, 32'h0, -1, 32'h0, reqs, lat, stable);
        chk("sat_hold", timeout_count, 3);
        chk("sat_err", rsp_error, 1);
        @(negedge clock);
        // reset in the middle of a write
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_index = 32'h33; cmd_data = 32'h44;
        @(negedge clock);
        cmd_valid = 1'b0;
        chk("mid_write_req", {write_req, write_index, write_data}, {1'b1, 32'h33, 32'h44});
        #1 reset = 1'b1;
        #1;
        chk("mid_rst_req", {write_req, read_req, write_index, write_data}, 0);
        chk("mid_rst_state", {cmd_ready, rsp_valid, rsp_write, rsp_error}, 4'b1000);
        chk("mid_rst_data", rsp_data, 0);
        chk("mid_rst_tcount", timeout_count, 0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        do_cmd(1'b1, 32'h6, 32'hBEEF, 1, 32'h0, reqs, lat, stable);
        chk("post_rst_reqs", reqs, 2);
        chk("post_rst_lat", lat, 3);
        chk("post_rst_stable", stable, 1);
        chk("post_rst_rsp", {rsp_valid, rsp_write, rsp_error, timeout_count}, 5'b11000);
        @(negedge clock);
        chk("post_rst_done", cmd_ready, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
